// File: rtl/idli_pkg.sv
// Shared types and constants for the idli instruction-fetch sequencer.
package idli_pkg;

    typedef enum logic [2:0] {
        ST_GAP   = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_HOLD  = 3'd5
    } fch_state_t;

    localparam int unsigned SQI_ADDR_NIBBLES = 6;

    // Nibble idx (0 = MS) of the 24b byte address of halfword pc.
    function automatic logic [3:0] addr_nibble(input logic [15:0] pc, input logic [3:0] idx);
        logic [23:0] addr;
        logic [3:0]  nib;
        addr = {7'b0, pc, 1'b0};
        case (idx)
            4'd0:    nib = addr[23:20];
            4'd1:    nib = addr[19:16];
            4'd2:    nib = addr[15:12];
            4'd3:    nib = addr[11:8];
            4'd4:    nib = addr[7:4];
            4'd5:    nib = addr[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// SQI instruction-fetch sequencer: command/address/dummy phases, then a
// nibble stream of 16b instructions with boundary stalls and redirects.
module idli_fetch_m
    import idli_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  RD_CMD       = 8'hEB
) (
    input  logic        i_fch_gck,
    input  logic        i_fch_rst,
    input  logic        i_fch_stall,
    input  logic        i_fch_redirect,
    input  logic [15:0] i_fch_redirect_pc,
    output logic        o_fch_redirect_ack,
    output logic        o_fch_sqi_cs_n,
    output logic        o_fch_sqi_sck_en,
    output logic        o_fch_sqi_oe,
    output logic [3:0]  o_fch_sqi_dout,
    input  logic [3:0]  i_fch_sqi_din,
    output logic [3:0]  o_fch_enc,
    output logic        o_fch_enc_vld,
    output logic [15:0] o_fch_pc
);

    localparam logic [3:0] ADDR_LAST  = 4'(SQI_ADDR_NIBBLES - 1);
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

    fch_state_t  state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [1:0]  nib_r, nib_s;
    logic [15:0] pc_r, pc_s;
    logic        take_s;

    // A redirect is never taken mid-instruction; otherwise it is taken at once.
    assign take_s = i_fch_redirect && ((state_r != ST_DATA) || (nib_r == 2'd3));

    assign o_fch_redirect_ack = take_s;
    assign o_fch_enc          = i_fch_sqi_din;
    assign o_fch_pc           = pc_r;

    // Next-state, counters and pad/decoder output decode.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        nib_s            = nib_r;
        pc_s             = pc_r;
        o_fch_sqi_cs_n   = 1'b0;
        o_fch_sqi_sck_en = 1'b1;
        o_fch_sqi_oe     = 1'b0;
        o_fch_sqi_dout   = 4'h0;
        o_fch_enc_vld    = 1'b0;
        case (state_r)
            ST_GAP: begin
                o_fch_sqi_cs_n   = 1'b1;
                o_fch_sqi_sck_en = 1'b0;
                state_s          = ST_CMD;
                cnt_s            = 4'd0;
            end
            ST_CMD: begin
                o_fch_sqi_oe = 1'b1;
                if (cnt_r == 4'd0) begin
                    o_fch_sqi_dout = RD_CMD[7:4];
                    cnt_s          = 4'd1;
                end else begin
                    o_fch_sqi_dout = RD_CMD[3:0];
                    cnt_s          = 4'd0;
                    state_s        = ST_ADDR;
                end
            end
            ST_ADDR: begin
                o_fch_sqi_oe   = 1'b1;
                o_fch_sqi_dout = addr_nibble(pc_r, cnt_r);
                if (cnt_r == ADDR_LAST) begin
                    cnt_s   = 4'd0;
                    state_s = ST_DUMMY;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_DUMMY: begin
                if (cnt_r == DUMMY_LAST) begin
                    cnt_s   = 4'd0;
                    nib_s   = 2'd0;
                    state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_DATA: begin
                o_fch_enc_vld = 1'b1;
                nib_s         = nib_r + 2'd1;
                if (nib_r == 2'd3) begin
                    pc_s = pc_r + 16'd1;
                    if (i_fch_stall) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_HOLD: begin
                // Memory clock stopped so the device keeps its stream position.
                o_fch_sqi_sck_en = 1'b0;
                if (i_fch_stall) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                o_fch_sqi_cs_n   = 1'b1;
                o_fch_sqi_sck_en = 1'b0;
                state_s          = ST_GAP;
            end
        endcase
        if (take_s) begin
            state_s = ST_GAP;
            cnt_s   = 4'd0;
            pc_s    = i_fch_redirect_pc;
        end else begin
            state_s = state_s;
        end
    end

    // State, phase counter, nibble position and PC registers.
    always_ff @(posedge i_fch_gck) begin
        if (i_fch_rst) begin
            state_r <= ST_GAP;
            cnt_r   <= 4'd0;
            nib_r   <= 2'd0;
            pc_r    <= 16'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            nib_r   <= nib_s;
            pc_r    <= pc_s;
        end
    end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Self-checking bench for idli_fetch_m: transaction-level model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_idli_fetch_m;

    localparam int D     = 4;
    localparam int SETUP = 9 + D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        redirect_ack;
    logic        cs_n, sck_en, oe;
    logic [3:0]  dout;
    logic [3:0]  din = 4'h0;
    logic [3:0]  enc;
    logic        enc_vld;
    logic [15:0] pc;

    int total = 0;
    int bad   = 0;

    idli_fetch_m #(.DUMMY_CYCLES(D), .RD_CMD(8'hEB)) dut (
        .i_fch_gck         (clk),
        .i_fch_rst         (rst),
        .i_fch_stall       (stall),
        .i_fch_redirect    (redirect),
        .i_fch_redirect_pc (redirect_pc),
        .o_fch_redirect_ack(redirect_ack),
        .o_fch_sqi_cs_n    (cs_n),
        .o_fch_sqi_sck_en  (sck_en),
        .o_fch_sqi_oe      (oe),
        .o_fch_sqi_dout    (dout),
        .i_fch_sqi_din     (din),
        .o_fch_enc         (enc),
        .o_fch_enc_vld     (enc_vld),
        .o_fch_pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory data: repeating A,5,3,C pattern, one nibble per cycle.
    initial begin
        logic [15:0] pat;
        int          idx;
        pat = 16'hA53C;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            din = pat[15 - 4*(idx % 4) -: 4];
            idx++;
        end
    end

    // Model: k = cycle index within a new transaction, then streaming with
    // an instruction-relative nibble position and an optional hold.
    initial begin
        bit          en, streaming, hold;
        int          k, pos;
        logic [15:0] m_pc;
        bit          n_stream, n_hold;
        int          n_k, n_pos;
        logic [15:0] n_pc;
        logic        e_cs, e_sck, e_oe, e_vld, e_ack;
        logic [3:0]  e_dout;
        logic [23:0] a;
        logic [7:0]  c;
        en = 0; streaming = 0; hold = 0; k = 0; pos = 0; m_pc = 16'h0;
        forever begin
            @(negedge clk);
            e_cs = 1'b0; e_sck = 1'b1; e_oe = 1'b0; e_vld = 1'b0; e_dout = 4'h0;
            if (!streaming) begin
                if (k == 0) begin
                    e_cs = 1'b1; e_sck = 1'b0;
                end else if (k <= 2) begin
                    c = 8'hEB;
                    e_oe = 1'b1;
                    e_dout = (k == 1) ? c[7:4] : c[3:0];
                end else if (k <= 8) begin
                    a = {7'b0, m_pc, 1'b0};
                    a = a >> (4 * (8 - k));
                    e_oe = 1'b1;
                    e_dout = a[3:0];
                end
            end else if (hold) begin
                e_sck = 1'b0;
            end else begin
                e_vld = 1'b1;
            end
            e_ack = redirect && (!streaming || hold || pos == 3);
            if (en) begin
                chk("m_cs_n", cs_n, e_cs);
                chk("m_sck_en", sck_en, e_sck);
                chk("m_oe", oe, e_oe);
                chk("m_dout", dout, e_dout);
                chk("m_vld", enc_vld, e_vld);
                chk("m_ack", redirect_ack, e_ack);
                chk("m_pc", pc, m_pc);
                if (e_vld) chk("m_enc", enc, din);
            end
            n_stream = streaming; n_hold = hold; n_k = k; n_pos = pos; n_pc = m_pc;
            if (rst) begin
                n_stream = 0; n_hold = 0; n_k = 0; n_pos = 0; n_pc = 16'h0;
            end else if (e_ack) begin
                n_stream = 0; n_hold = 0; n_k = 0; n_pos = 0; n_pc = redirect_pc;
            end else if (!streaming) begin
                n_k = k + 1;
                if (n_k == SETUP) begin
                    n_stream = 1; n_pos = 0; n_hold = 0;
                end
            end else if (hold) begin
                n_hold = stall;
            end else if (pos == 3) begin
                n_pc = m_pc + 16'd1; n_pos = 0; n_hold = stall;
            end else begin
                n_pos = pos + 1;
            end
            @(posedge clk);
            if (rst) en = 1;
            streaming = n_stream; hold = n_hold; k = n_k; pos = n_pos; m_pc = n_pc;
        end
    end

    initial begin
        logic [31:0] cmd_seq, adr_seq;
        cmd_seq = 32'hEB000000;
        adr_seq = 32'h00246800;

        // Reset, then unstalled streaming.
        tick(2);
        rst = 1'b0;                                  // cycle 0: GAP
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sck", sck_en, 1'b0);
        chk("rst_pc", pc, 16'h0);
        chk("rst_vld", enc_vld, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1);                                 // cycles 1..8
            chk("cmd_addr_dout", dout, cmd_seq[31 - 4*i -: 4]);
            if (i == 0) chk("cs_fall", cs_n, 1'b0);
        end
        tick(4);
        chk("vld_c12", enc_vld, 1'b0);
        tick(1);
        chk("vld_c13", enc_vld, 1'b1);
        chk("pc_i0", pc, 16'h0);
        tick(4);
        chk("pc_i1", pc, 16'h1);
        tick(4);
        chk("pc_i2", pc, 16'h2);

        // Redirect during ADDR.
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(4);
        redirect = 1'b1; redirect_pc = 16'h1234; #1;
        chk("ack_addr", redirect_ack, 1'b1);
        tick(1);
        redirect = 1'b0; #1;
        chk("rd_gap_cs", cs_n, 1'b1);
        chk("rd_pc", pc, 16'h1234);
        tick(2);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("rd_addr", dout, adr_seq[31 - 4*i -: 4]);
        end

        // Redirect held from nib 1: taken only at nib 3.
        tick(5);                                     // DATA nib0
        tick(1);                                     // nib1
        redirect = 1'b1; redirect_pc = 16'h0040; #1;
        chk("hold_ack_n1", redirect_ack, 1'b0);
        tick(1);
        chk("hold_ack_n2", redirect_ack, 1'b0);
        tick(1);
        chk("hold_ack_n3", redirect_ack, 1'b1);
        chk("hold_vld_n3", enc_vld, 1'b1);
        tick(1);
        redirect = 1'b0; #1;
        chk("after_ack_vld", enc_vld, 1'b0);
        chk("after_ack_pc", pc, 16'h0040);

        // Stall raised at nib 1 for 5 cycles.
        tick(13);                                    // cycle 13, nib0
        tick(1);                                     // cycle 14, nib1
        stall = 1'b1;
        tick(3);                                     // cycle 17: HOLD
        chk("st_vld", enc_vld, 1'b0);
        chk("st_sck", sck_en, 1'b0);
        chk("st_cs", cs_n, 1'b0);
        chk("st_pc", pc, 16'h0041);
        tick(2);                                     // cycle 19
        stall = 1'b0; #1;
        chk("st_rel_vld", enc_vld, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1);                                 // cycles 20..23
            chk("st_resume_vld", enc_vld, 1'b1);
        end
        chk("st_resume_pc", pc, 16'h0041);
        tick(1);
        chk("st_next_pc", pc, 16'h0042);

        // Stall and redirect together at nib 3: redirect wins.
        tick(3);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100; #1;
        chk("sr_ack", redirect_ack, 1'b1);
        tick(1);
        stall = 1'b0; redirect = 1'b0; #1;
        chk("sr_gap_cs", cs_n, 1'b1);
        chk("sr_pc", pc, 16'h0100);
        tick(1);
        chk("sr_cmd_oe", oe, 1'b1);

        // Reset at DATA nib 2.
        tick(12);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; #1;
        chk("mr_cs", cs_n, 1'b1);
        chk("mr_sck", sck_en, 1'b0);
        chk("mr_oe", oe, 1'b0);
        chk("mr_dout", dout, 4'h0);
        chk("mr_vld", enc_vld, 1'b0);
        chk("mr_ack", redirect_ack, 1'b0);
        chk("mr_pc", pc, 16'h0);

        // PC wrap from 16'hFFFF.
        redirect = 1'b1; redirect_pc = 16'hFFFF; #1;
        chk("wr_ack", redirect_ack, 1'b1);
        tick(1);
        redirect = 1'b0; #1;
        chk("wr_pc", pc, 16'hFFFF);
        tick(13);
        chk("wr_vld", enc_vld, 1'b1);
        tick(4);
        chk("wr_pc0", pc, 16'h0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
